z80_io_capture: RTL
===================

Name: z80_io_capture

Overview:
- Upstream front-end for the Z80 I/O mailbox and SPI bridge.
- Samples the asynchronous Z80 bus into the `clk` domain and debounces the I/O strobes.
- Decodes the mailbox port window and emits one single-cycle, fully qualified read or write event per Z80 I/O cycle.
- The mailbox consumes `io_wr_stb` with `io_idx`/`io_wdata` to update its Z80-to-SPI bytes, and uses `io_rd_stb` to mark SPI-to-Z80 bytes as consumed.

Parameters:
- SYNC_STAGES, 2: flip-flop depth of the synchroniser on every sampled bus input (minimum 2).
- FILTER_LEN, 3: consecutive identical qualified samples needed to accept a cycle start or a cycle end (1..7).
- BASE_ADDR, 16'd12345: full 16-bit I/O address of mailbox slot 0.
- NUM_SLOTS, 8: number of slots. Slot k sits at BASE_ADDR + 2*k.

Ports:
- clk  in  1  internal HFOSC clock; everything is sampled on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- z80_a  in  16  Z80 address bus (asynchronous).
- z80_d_in  in  8  Z80 data bus, input copy only (asynchronous).
- z80_rd, z80_wr, z80_m1, z80_iorq, z80_mreq  in  1 each  Z80 control, active-low (asynchronous).
- io_wr_stb  out  1  one-cycle pulse: a qualified write was accepted.
- io_rd_stb  out  1  one-cycle pulse: a qualified read was accepted.
- io_idx  out  3  slot index k of the accepted cycle.
- io_wdata  out  8  write data captured for the accepted write.
- io_busy  out  1  high from cycle start until the cycle is released.
- err_cnt  out  8  saturating count of protocol errors.

Behaviour:
- Reset: all synchroniser flops load idle levels (controls 1, bus 0). All outputs go to 0 and the state goes to IDLE. Reset is asynchronous assert with synchronous release. Reset mid-cycle drops the cycle with no strobe. After release, a cycle still in progress on the bus does not fire a strobe; the block waits for the bus to go idle first.
- Synchroniser: every input passes through SYNC_STAGES flops. The term "sample" below means the last stage.
- Qualified I/O (qio) = !iorq & mreq & m1 & (rd ^ wr).
  - Slot hit: (a - BASE_ADDR) is even and (a - BASE_ADDR)/2 < NUM_SLOTS. The subtraction is 16-bit modular, so addresses below BASE_ADDR wrap to large values and miss.
  - Interrupt acknowledge (!m1 & !iorq) is never qualified.
- State machine:
  - IDLE: qio & hit → QUAL, load filt_cnt = 1, latch the candidate (addr, rd/wr type).
  - QUAL: each sample with qio, hit, and the same addr and type increments filt_cnt. Any mismatch returns to IDLE (glitch rejected, no error). When filt_cnt == FILTER_LEN → FIRE.
  - FIRE (one cycle): pulse io_wr_stb or io_rd_stb, drive io_idx, and load io_wdata from the current data sample (writes only). Go to HOLD.
  - HOLD: wait for !qio on FILTER_LEN consecutive samples → IDLE. If the addr or type changes while qio remains asserted, increment err_cnt and stay in HOLD; no second strobe.
  - WAIT_IDLE: used only after reset. The block must see !qio for FILTER_LEN consecutive samples before entering IDLE.
- Outputs while idle and after a strobe:
  - io_idx and io_wdata hold their values until the next FIRE.
  - Strobes are 0 outside FIRE.
  - io_busy = 1 in QUAL, FIRE and HOLD.
- Latency: a strobe appears SYNC_STAGES + FILTER_LEN + 1 clocks after the bus edge. With defaults that is 6 clocks, about 125 ns at 48 MHz, well inside a Z80 I/O cycle.
- Simultaneous rd & wr low: not qio. If this happens while in HOLD, err_cnt increments once per entry into that condition.
- err_cnt saturates at 8'hFF.
- At most one strobe is produced per Z80 I/O cycle. io_wr_stb and io_rd_stb are never high together.

Test Plan:
- OUT to BASE_ADDR+6 with data 8'hA5, strobes held 300 ns → exactly one io_wr_stb, io_idx=3, io_wdata=8'hA5, 6 clocks after WR falls. io_busy drops 5 clocks after IORQ rises.
- IN from BASE_ADDR+14 → one io_rd_stb with io_idx=7. Access to BASE_ADDR+1 (odd) and BASE_ADDR+16 (out of range) → no strobe, io_busy stays 0.
- IORQ glitch low for 2 clocks at BASE_ADDR → no strobe and err_cnt=0. The same access held low for 3 or more clocks → one strobe.
- Interrupt acknowledge (M1 low with IORQ low) at BASE_ADDR → no strobe. Memory cycle (MREQ low) at BASE_ADDR → no strobe.
- In HOLD, change the address to BASE_ADDR+2 while IORQ stays low → err_cnt=1 and no second strobe. Repeat 300 times → err_cnt=8'hFF.
- Assert rst_n low during QUAL → outputs 0 immediately. Release while the bus is still mid-cycle → no strobe for that cycle; the next full OUT produces a normal strobe.

Source files
------------

// File: rtl/z80_io_capture.sv
// Z80 I/O front-end: synchronises the asynchronous Z80 bus, filters the I/O strobes
// and emits one qualified read or write event per mailbox I/O cycle.
module z80_io_capture #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 3,
  parameter logic [15:0] BASE_ADDR   = 16'd12345,
  parameter int unsigned NUM_SLOTS   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] z80_a,
  input  logic [7:0]  z80_d_in,
  input  logic        z80_rd,
  input  logic        z80_wr,
  input  logic        z80_m1,
  input  logic        z80_iorq,
  input  logic        z80_mreq,
  output logic        io_wr_stb,
  output logic        io_rd_stb,
  output logic [2:0]  io_idx,
  output logic [7:0]  io_wdata,
  output logic        io_busy,
  output logic [7:0]  err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUAL,
    S_FIRE,
    S_HOLD,
    S_WAIT_IDLE
  } state_t;

  localparam logic [2:0] FLEN = 3'(FILTER_LEN);

  // Asynchronous assert, synchronous release.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= '0;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  // Control vector order: {rd, wr, m1, iorq, mreq}; idle level is all ones.
  logic [SYNC_STAGES-1:0][15:0] r_a_sync;
  logic [SYNC_STAGES-1:0][7:0]  r_d_sync;
  logic [SYNC_STAGES-1:0][4:0]  r_c_sync;
  logic [4:0]                   w_c_in;

  assign w_c_in = {z80_rd, z80_wr, z80_m1, z80_iorq, z80_mreq};

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_a_sync <= '0;
      r_d_sync <= '0;
      r_c_sync <= '1;
    end else begin
      r_a_sync <= {r_a_sync[SYNC_STAGES-2:0], z80_a};
      r_d_sync <= {r_d_sync[SYNC_STAGES-2:0], z80_d_in};
      r_c_sync <= {r_c_sync[SYNC_STAGES-2:0], w_c_in};
    end
  end

  logic [15:0] w_a;
  logic [7:0]  w_d;
  logic        w_rd, w_wr, w_m1, w_iorq, w_mreq;
  logic        w_qio, w_is_wr, w_both;
  logic [15:0] w_off;
  logic        w_hit;

  assign w_a = r_a_sync[SYNC_STAGES-1];
  assign w_d = r_d_sync[SYNC_STAGES-1];
  assign {w_rd, w_wr, w_m1, w_iorq, w_mreq} = r_c_sync[SYNC_STAGES-1];

  assign w_qio   = !w_iorq && w_mreq && w_m1 && (w_rd ^ w_wr);
  assign w_is_wr = !w_wr;
  assign w_both  = !w_rd && !w_wr;

  // Modular subtraction makes addresses below the window wrap high and miss.
  assign w_off = w_a - BASE_ADDR;
  assign w_hit = !w_off[0] && (32'(w_off[15:1]) < NUM_SLOTS);

  state_t      r_state;
  logic [2:0]  r_cnt;
  logic [15:0] r_cand_a;
  logic        r_cand_wr;
  logic [2:0]  r_cand_idx;
  logic        r_wr_stb, r_rd_stb, r_busy;
  logic [2:0]  r_idx;
  logic [7:0]  r_wdata, r_err;
  logic        r_mis, r_both;
  logic        w_match, w_mis;

  assign w_match = (w_a == r_cand_a) && (w_is_wr == r_cand_wr);
  assign w_mis   = w_qio && !w_match;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state    <= S_WAIT_IDLE;
      r_cnt      <= '0;
      r_cand_a   <= '0;
      r_cand_wr  <= 1'b0;
      r_cand_idx <= '0;
      r_wr_stb   <= 1'b0;
      r_rd_stb   <= 1'b0;
      r_busy     <= 1'b0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_err      <= '0;
      r_mis      <= 1'b0;
      r_both     <= 1'b0;
    end else begin
      r_wr_stb <= 1'b0;
      r_rd_stb <= 1'b0;
      case (r_state)
        S_WAIT_IDLE: begin
          if (w_qio) begin
            r_cnt <= '0;
          end else if (r_cnt + 3'd1 == FLEN) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        S_IDLE: begin
          if (w_qio && w_hit) begin
            r_cand_a   <= w_a;
            r_cand_wr  <= w_is_wr;
            r_cand_idx <= w_off[3:1];
            r_cnt      <= 3'd1;
            r_busy     <= 1'b1;
            r_state    <= (FLEN == 3'd1) ? S_FIRE : S_QUAL;
          end
        end
        S_QUAL: begin
          if (w_qio && w_hit && w_match) begin
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt + 3'd1 == FLEN) r_state <= S_FIRE;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_FIRE: begin
          if (r_cand_wr) begin
            r_wr_stb <= 1'b1;
            r_wdata  <= w_d;
          end else begin
            r_rd_stb <= 1'b1;
          end
          r_idx   <= r_cand_idx;
          r_cnt   <= '0;
          r_mis   <= 1'b0;
          r_both  <= 1'b0;
          r_state <= S_HOLD;
        end
        S_HOLD: begin
          // Errors count on entry into a bad condition, not per sample spent in it.
          r_mis  <= w_mis;
          r_both <= w_both;
          if (((w_mis && !r_mis) || (w_both && !r_both)) && (r_err != '1))
            r_err <= r_err + 8'd1;
          if (w_qio) begin
            r_cnt <= '0;
          end else if (r_cnt + 3'd1 == FLEN) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_WAIT_IDLE;
        end
      endcase
    end
  end

  assign io_wr_stb = r_wr_stb;
  assign io_rd_stb = r_rd_stb;
  assign io_idx    = r_idx;
  assign io_wdata  = r_wdata;
  assign io_busy   = r_busy;
  assign err_cnt   = r_err;

endmodule
